// File: rtl/riscv_dmem_arb.sv
// Shares the data-memory bus between instruction fetch (IF) and load/store (LS), LS first.
// Define RISCV_DMEM_ARB_STARVE_EN to add the guard that forces an IF grant after STARVE_LIMIT LS grants.
module riscv_dmem_arb
`ifdef RISCV_DMEM_ARB_STARVE_EN
#(
    parameter int STARVE_LIMIT = 4
)
`endif
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_req_rdy,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ack,
    output logic        if_rsp_rdy,
    output logic [31:0] if_rsp_data,
    input  logic        ls_req_rdy,
    input  logic [31:0] ls_req_addr,
    input  logic        ls_req_we,
    input  logic [31:0] ls_req_wdata,
    input  logic [3:0]  ls_req_be,
    output logic        ls_req_ack,
    output logic        ls_rsp_rdy,
    output logic [31:0] ls_rsp_data,
    output logic        bus_req_rdy,
    input  logic        bus_req_ack,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_rsp_rdy,
    input  logic [31:0] bus_rsp_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state_q, state_d;
    logic        owner_ls_q, owner_ls_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic        if_rsp_rdy_q, if_rsp_rdy_d;
    logic        ls_rsp_rdy_q, ls_rsp_rdy_d;
    logic [31:0] if_rsp_data_q, if_rsp_data_d;
    logic [31:0] ls_rsp_data_q, ls_rsp_data_d;
    logic        grant_if, grant_ls, force_if, complete;

`ifdef RISCV_DMEM_ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign force_if = if_req_rdy && (starve_cnt_q == STARVE_LIMIT_C);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_ls && if_req_rdy) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else if (grant_ls || grant_if) begin
            starve_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    // Grants are only made from IDLE, so at most one transaction is ever in flight.
    always_comb begin
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (state_q == IDLE && rstn) begin
            grant_ls = ls_req_rdy && !force_if;
            grant_if = if_req_rdy && !grant_ls;
        end
        complete = ((state_q == ISSUE) && bus_req_ack && bus_rsp_rdy) ||
                   ((state_q == WAIT) && bus_rsp_rdy);
    end

    always_comb begin
        state_d       = state_q;
        owner_ls_d    = owner_ls_q;
        bus_addr_d    = bus_addr_q;
        bus_we_d      = bus_we_q;
        bus_wdata_d   = bus_wdata_q;
        bus_be_d      = bus_be_q;
        if_rsp_rdy_d  = 1'b0;
        ls_rsp_rdy_d  = 1'b0;
        if_rsp_data_d = if_rsp_data_q;
        ls_rsp_data_d = ls_rsp_data_q;
        case (state_q)
            IDLE: begin
                if (grant_ls) begin
                    state_d     = ISSUE;
                    owner_ls_d  = 1'b1;
                    bus_addr_d  = ls_req_addr;
                    bus_we_d    = ls_req_we;
                    bus_wdata_d = ls_req_wdata;
                    bus_be_d    = ls_req_be;
                end else if (grant_if) begin
                    state_d     = ISSUE;
                    owner_ls_d  = 1'b0;
                    bus_addr_d  = if_req_addr;
                    bus_we_d    = 1'b0;
                    bus_wdata_d = 32'd0;
                    bus_be_d    = 4'hF;
                end
            end
            ISSUE: begin
                if (bus_req_ack) begin
                    state_d = complete ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (complete) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Response is steered to the owner only; the other requester's data register holds.
        if (complete) begin
            if (owner_ls_q) begin
                ls_rsp_rdy_d  = 1'b1;
                ls_rsp_data_d = bus_rsp_data;
            end else begin
                if_rsp_rdy_d  = 1'b1;
                if_rsp_data_d = bus_rsp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            owner_ls_q    <= 1'b0;
            bus_addr_q    <= 32'd0;
            bus_we_q      <= 1'b0;
            bus_wdata_q   <= 32'd0;
            bus_be_q      <= 4'd0;
            if_rsp_rdy_q  <= 1'b0;
            ls_rsp_rdy_q  <= 1'b0;
            if_rsp_data_q <= 32'd0;
            ls_rsp_data_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            owner_ls_q    <= owner_ls_d;
            bus_addr_q    <= bus_addr_d;
            bus_we_q      <= bus_we_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_be_q      <= bus_be_d;
            if_rsp_rdy_q  <= if_rsp_rdy_d;
            ls_rsp_rdy_q  <= ls_rsp_rdy_d;
            if_rsp_data_q <= if_rsp_data_d;
            ls_rsp_data_q <= ls_rsp_data_d;
        end
    end

    assign if_req_ack  = grant_if;
    assign ls_req_ack  = grant_ls;
    assign if_rsp_rdy  = if_rsp_rdy_q;
    assign ls_rsp_rdy  = ls_rsp_rdy_q;
    assign if_rsp_data = if_rsp_data_q;
    assign ls_rsp_data = ls_rsp_data_q;
    assign bus_req_rdy = (state_q == ISSUE);
    assign bus_addr    = bus_addr_q;
    assign bus_we      = bus_we_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_be      = bus_be_q;
endmodule

// File: tb/tb_riscv_dmem_arb.sv
// Scoreboard bench for riscv_dmem_arb: random requesters and bus, reference model of arbitration and routing.
module tb_riscv_dmem_arb;
`ifdef RISCV_DMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req_rdy, if_req_ack, if_rsp_rdy;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        ls_req_rdy, ls_req_we, ls_req_ack, ls_rsp_rdy;
    logic [31:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
    logic [3:0]  ls_req_be;
    logic        bus_req_rdy, bus_req_ack, bus_we, bus_rsp_rdy;
    logic [31:0] bus_addr, bus_wdata, bus_rsp_data;
    logic [3:0]  bus_be;

    riscv_dmem_arb dut (
        .clk(clk), .rstn(rstn),
        .if_req_rdy(if_req_rdy), .if_req_addr(if_req_addr), .if_req_ack(if_req_ack),
        .if_rsp_rdy(if_rsp_rdy), .if_rsp_data(if_rsp_data),
        .ls_req_rdy(ls_req_rdy), .ls_req_addr(ls_req_addr), .ls_req_we(ls_req_we),
        .ls_req_wdata(ls_req_wdata), .ls_req_be(ls_req_be), .ls_req_ack(ls_req_ack),
        .ls_rsp_rdy(ls_rsp_rdy), .ls_rsp_data(ls_rsp_data),
        .bus_req_rdy(bus_req_rdy), .bus_req_ack(bus_req_ack), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rsp_rdy(bus_rsp_rdy), .bus_rsp_data(bus_rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ls;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    int n_chk = 0, n_err = 0;
    int cyc = 0, last_ack_cyc = 0, last_rsp_cyc = 0, n_rsp = 0;
    logic [31:0] last_rsp_data = 0;
    txn_t txq[$];
    bit   grants[$];
    bit   m_acc = 0, rp_valid = 0, rp_ls = 0, rst_smp = 0;
    logic [31:0] rp_data = 0, m_if_data = 0, m_ls_data = 0;
    int   m_starve = 0;
    bit   if_acked = 0, ls_acked = 0;

    // stimulus knobs
    int   if_budget = 0, ls_budget = 0;
    bit   if_always = 0, ls_always = 0, fix_fields = 0;
    logic [31:0] if_addr_k = 0, ls_addr_k = 0, ls_wdata_k = 0, rsp_val = 0;
    logic ls_we_k = 0;
    logic [3:0] ls_be_k = 0;
    bit   rand_bus = 0, spur_en = 0, same_cyc = 0;
    int   ack_dly = 0, rsp_dly = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic reroll();
        if (rand_bus) begin
            ack_dly  = $urandom_range(0, 3);
            rsp_dly  = $urandom_range(0, 3);
            same_cyc = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic wait_quiet(input int limit);
        bit done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            step();
            done = (if_budget == 0) && (ls_budget == 0) && !if_req_rdy && !ls_req_rdy &&
                   (txq.size() == 0) && !rp_valid;
        end
        check("quiet_timeout", {127'd0, !done}, 128'd0);
        step();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            rst_smp = rstn;
        end
    end

    // requester drivers
    initial begin
        if_req_rdy = 0; if_req_addr = 0;
        ls_req_rdy = 0; ls_req_addr = 0; ls_req_we = 0; ls_req_wdata = 0; ls_req_be = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                if_req_rdy = 0;
                ls_req_rdy = 0;
            end else begin
                if (if_req_rdy && if_acked) if_req_rdy = 0;
                if (ls_req_rdy && ls_acked) ls_req_rdy = 0;
                if (!if_req_rdy && if_budget > 0 && (if_always || $urandom_range(0, 2) == 0)) begin
                    if_req_rdy  = 1;
                    if_req_addr = fix_fields ? if_addr_k : $urandom;
                    if_budget--;
                end
                if (!ls_req_rdy && ls_budget > 0 && (ls_always || $urandom_range(0, 2) == 0)) begin
                    ls_req_rdy   = 1;
                    ls_req_addr  = fix_fields ? ls_addr_k : $urandom;
                    ls_req_we    = fix_fields ? ls_we_k : 1'($urandom);
                    ls_req_wdata = fix_fields ? ls_wdata_k : $urandom;
                    ls_req_be    = fix_fields ? ls_be_k : 4'($urandom);
                    ls_budget--;
                end
            end
        end
    end

    // bus responder
    initial begin
        int wcnt = 0;
        bus_req_ack = 0; bus_rsp_rdy = 0; bus_rsp_data = 0;
        forever begin
            @(posedge clk);
            #1;
            bus_req_ack = 0;
            bus_rsp_rdy = 0;
            if (!rstn) begin
                wcnt = 0;
            end else if (bus_req_rdy && !m_acc) begin
                if (wcnt >= ack_dly) begin
                    bus_req_ack = 1;
                    wcnt = 0;
                    if (same_cyc) begin
                        bus_rsp_rdy  = 1;
                        bus_rsp_data = rand_bus ? $urandom : rsp_val;
                        reroll();
                    end
                end else wcnt++;
            end else if (m_acc) begin
                if (wcnt >= rsp_dly) begin
                    bus_rsp_rdy  = 1;
                    bus_rsp_data = rand_bus ? $urandom : rsp_val;
                    wcnt = 0;
                    reroll();
                end else wcnt++;
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                bus_rsp_rdy  = 1;
                bus_rsp_data = $urandom;
            end
        end
    end

    // monitor and scoreboard
    initial begin
        int  sz0;
        bit  exp_if_r, exp_ls_r, exp_if_a, exp_ls_a, force_if;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                if (!rst_smp)
                    check("reset_outputs", {127'd0, |{if_req_ack, if_rsp_rdy, if_rsp_data, ls_req_ack,
                          ls_rsp_rdy, ls_rsp_data, bus_req_rdy, bus_addr, bus_we, bus_wdata, bus_be}}, 128'd0);
                txq.delete();
                m_acc = 0; rp_valid = 0; m_starve = 0;
                m_if_data = 0; m_ls_data = 0;
                if_acked = 0; ls_acked = 0;
            end else begin
                exp_if_r = rp_valid && !rp_ls;
                exp_ls_r = rp_valid && rp_ls;
                if (exp_if_r) m_if_data = rp_data;
                if (exp_ls_r) m_ls_data = rp_data;
                rp_valid = 0;
                check("rsp_rdy", {126'd0, if_rsp_rdy, ls_rsp_rdy}, {126'd0, exp_if_r, exp_ls_r});
                check("rsp_data", {64'd0, if_rsp_data, ls_rsp_data}, {64'd0, m_if_data, m_ls_data});
                if (if_rsp_rdy || ls_rsp_rdy) begin
                    n_rsp++;
                    last_rsp_cyc  = cyc;
                    last_rsp_data = if_rsp_rdy ? if_rsp_data : ls_rsp_data;
                end
                sz0 = txq.size();
                check("bus_req_rdy", {127'd0, bus_req_rdy}, {127'd0, (sz0 != 0) && !m_acc});
                if (bus_req_rdy && sz0 != 0)
                    check("bus_fields", {59'd0, bus_addr, bus_we, bus_wdata, bus_be},
                          {59'd0, txq[0].addr, txq[0].we, txq[0].wdata, txq[0].be});
                if (sz0 != 0) begin
                    if ((!m_acc && bus_req_ack && bus_rsp_rdy) || (m_acc && bus_rsp_rdy)) begin
                        rp_valid = 1;
                        rp_ls    = txq[0].ls;
                        rp_data  = bus_rsp_data;
                        void'(txq.pop_front());
                        m_acc = 0;
                    end else if (!m_acc && bus_req_ack) begin
                        m_acc = 1;
                    end
                end
                force_if = STARVE_EN && if_req_rdy && (m_starve == STARVE_LIMIT);
                exp_ls_a = (sz0 == 0) && ls_req_rdy && !force_if;
                exp_if_a = (sz0 == 0) && if_req_rdy && !exp_ls_a;
                check("req_acks", {126'd0, if_req_ack, ls_req_ack}, {126'd0, exp_if_a, exp_ls_a});
                if (exp_ls_a) begin
                    txq.push_back('{1'b1, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_be});
                    m_starve = if_req_rdy ? m_starve + 1 : 0;
                end else if (exp_if_a) begin
                    txq.push_back('{1'b0, if_req_addr, 1'b0, 32'd0, 4'hF});
                    m_starve = 0;
                end
                if (exp_ls_a || exp_if_a) begin
                    grants.push_back(exp_ls_a);
                    last_ack_cyc = cyc;
                end
                if_acked = if_req_ack;
                ls_acked = ls_req_ack;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ls, rsp_before;
        rstn = 0;
        repeat (3) step();
        rstn = 1;
        step();

        // single IF read, zero-wait bus
        fix_fields = 1; if_addr_k = 32'h100; rsp_val = 32'hDEADBEEF;
        ack_dly = 0; rsp_dly = 0; same_cyc = 0;
        grants.delete();
        if_always = 1; if_budget = 1;
        wait_quiet(50);
        check("if_read_latency", 128'(last_rsp_cyc - last_ack_cyc), 128'd3);
        check("if_read_data", {96'd0, last_rsp_data}, {96'd0, 32'hDEADBEEF});
        check("if_read_grant", {96'd0, 32'(grants.size()), 31'd0, grants[0]}, {96'd0, 32'd1, 32'd0});

        // LS store with bus ack delayed 3 cycles
        ls_addr_k = 32'h200; ls_we_k = 1; ls_wdata_k = 32'h12345678; ls_be_k = 4'b0011;
        rsp_val = 32'hCAFEF00D; ack_dly = 3;
        ls_always = 1; ls_budget = 1;
        wait_quiet(50);
        check("ls_store_latency", 128'(last_rsp_cyc - last_ack_cyc), 128'd6);
        check("ls_store_data", {96'd0, last_rsp_data}, {96'd0, 32'hCAFEF00D});

        // simultaneous requests: LS first, then IF
        ls_we_k = 0; ack_dly = 0; rsp_val = 32'h0BADCAFE;
        grants.delete();
        if_budget = 1; ls_budget = 1;
        wait_quiet(50);
        check("simul_order", {96'd0, 32'(grants.size()), 30'd0, grants[0], grants[1]},
              {96'd0, 32'd2, 30'd0, 1'b1, 1'b0});

        // bus ack and response in the same ISSUE cycle
        same_cyc = 1; rsp_val = 32'hA5A5A5A5;
        ls_budget = 1;
        wait_quiet(50);
        check("same_cycle_latency", 128'(last_rsp_cyc - last_ack_cyc), 128'd2);
        check("same_cycle_data", {96'd0, last_rsp_data}, {96'd0, 32'hA5A5A5A5});
        same_cyc = 0;

        // reset in the middle of WAIT, then stray bus responses
        rsp_dly = 20; if_budget = 1;
        for (int i = 0; i < 20 && !m_acc; i++) step();
        check("reset_reached_wait", {127'd0, m_acc}, 128'd1);
        repeat (2) step();
        rsp_before = n_rsp;
        rstn = 0;
        repeat (2) step();
        rstn = 1;
        rsp_dly = 0; spur_en = 1;
        repeat (12) step();
        spur_en = 0;
        check("reset_no_rsp", 128'(n_rsp - rsp_before), 128'd0);
        wait_quiet(20);

        // LS held pending with IF pending
        grants.delete();
        if_budget = 1; ls_budget = 20;
        wait_quiet(400);
        check("starve_grant_count", 128'(grants.size()), 128'd21);
        n_ls = 0;
        for (int i = 0; i < 20 && i < grants.size(); i++) n_ls += int'(grants[i]);
        check("starve_ls_in_first20", 128'(n_ls), STARVE_EN ? 128'd19 : 128'd20);
        if (STARVE_EN)
            for (int i = 0; i < 5 && i < grants.size(); i++)
                check("starve_pattern", {127'd0, grants[i]}, {127'd0, i != STARVE_LIMIT});

        // randomized traffic
        fix_fields = 0; if_always = 0; ls_always = 0;
        rand_bus = 1; spur_en = 1;
        reroll();
        if_budget = 60; ls_budget = 60;
        wait_quiet(4000);
        spur_en = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/riscv_dmem_arb.md
# riscv_dmem_arb

Two-requester arbiter sharing the single data-memory bus between instruction fetch (IF) and the load/store path of the memory stage (LS). It accepts one request at a time using the pipeline's rdy/ack handshake, drives it onto the bus, waits for the bus response and routes it back to the winning requester. LS has priority. An optional starvation guard bounds how long IF can be locked out.

## Interface
- STARVE_LIMIT, 4: consecutive LS grants with IF pending before IF is forced a grant (used only with the guard compiled in; legal range 1-15)
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- if_req_rdy  in  1  IF request valid; held with if_req_addr until acked
- if_req_addr  in  32  IF word address
- if_req_ack  out  1  IF request accepted this cycle
- if_rsp_rdy  out  1  one-cycle pulse, IF response valid
- if_rsp_data  out  32  IF read data
- ls_req_rdy  in  1  LS request valid; held with its fields until acked
- ls_req_addr  in  32  LS address
- ls_req_we  in  1  1 = store
- ls_req_wdata  in  32  store data
- ls_req_be  in  4  byte enables
- ls_req_ack  out  1  LS request accepted this cycle
- ls_rsp_rdy  out  1  one-cycle pulse, LS response valid
- ls_rsp_data  out  32  LS read data
- bus_req_rdy  out  1  bus request valid; held until bus_req_ack
- bus_req_ack  in  1  bus accepted request
- bus_addr  out  32  bus address
- bus_we  out  1  bus write
- bus_wdata  out  32  bus write data
- bus_be  out  4  bus byte enables; 4'hF for IF
- bus_rsp_rdy  in  1  bus response valid, one cycle
- bus_rsp_data  in  32  bus read data

## Operation
- States: IDLE, ISSUE, WAIT. Owner flag records the granted requester (IF/LS).
- IDLE: if any request pending, grant per arbitration, assert that requester's ack combinationally for this cycle, latch its fields into the bus registers (IF: we=0, wdata=0, be=4'hF), go to ISSUE. No request: stay.
- Arbitration: LS wins when both pending, unless the starvation guard forces IF.
- ISSUE: bus_req_rdy=1, bus fields stable. bus_req_ack=1 -> WAIT. If bus_req_ack and bus_rsp_rdy are both 1 in ISSUE, complete immediately (as WAIT completion below).
- WAIT: bus_req_rdy=0. bus_rsp_rdy=1 -> register bus_rsp_data into owner's rsp_data, pulse owner's rsp_rdy next cycle, go IDLE.
- Stores also complete via bus_rsp_rdy; ls_rsp_data carries bus_rsp_data unchanged.
- bus_rsp_rdy in IDLE is ignored. Non-owner rsp_rdy never asserts; rsp_data of non-owner holds its previous value.
- Reset (rstn=0 at clk edge) from any state: state IDLE, outstanding transaction dropped, all outputs 0, starve counter 0.

## Timing
- Reset values: every output 0 (acks, rsp_rdy, rsp_data, bus_req_rdy, bus_addr, bus_we, bus_wdata, bus_be).
- Cycle 0 request seen in IDLE -> ack in cycle 0; bus_req_rdy from cycle 1.
- Zero-wait bus (ack cycle 1, rsp cycle 2): rsp_rdy in cycle 3; next grant possible in cycle 3.
- Max one transaction outstanding; throughput one per 3 cycles minimum.
- Acks and bus_req_rdy are mutually exclusive with each other across requesters; at most one ack per cycle.

## Configuration
- RISCV_DMEM_ARB_STARVE_EN defined: 4-bit counter increments on each LS grant made while if_req_rdy=1; clears on an IF grant or on any grant with if_req_rdy=0. When counter == STARVE_LIMIT and IF is pending, IF wins the next arbitration.
- Not defined: strict LS priority; counter and STARVE_LIMIT absent/unused; IF may starve indefinitely.

## Test plan
- Reset: rstn=0 for 2 cycles mid-WAIT -> all outputs 0, state IDLE; later bus_rsp_rdy ignored, no rsp_rdy pulse.
- Single IF read addr 0x100, bus acks cycle 1, rsp 0xDEADBEEF cycle 2 -> if_req_ack cycle 0, bus_be=4'hF, bus_we=0, if_rsp_rdy=1 with 0xDEADBEEF cycle 3 only.
- LS store addr 0x200, wdata 0x12345678, be 4'b0011, bus ack delayed 3 cycles -> bus fields held stable through all 4 ISSUE cycles, ls_rsp_rdy one pulse after bus_rsp_rdy.
- Simultaneous IF and LS pending -> LS acked first; IF acked in IDLE after LS response.
- LS held continuously pending with IF pending, STARVE_LIMIT=4 -> with macro: 4 LS grants then IF grant; without macro: IF never granted over 20 transactions.
- bus_req_ack and bus_rsp_rdy same cycle in ISSUE with data 0xA5A5A5A5 -> owner rsp_rdy next cycle with 0xA5A5A5A5, state IDLE.
